// File: rtl/ch_mm_pkg.sv
// Shared types and constants for the per-channel CSR request bridge.
// Holds the bridge state encoding, the timeout error tag and default bus widths.
package ch_mm_pkg;

    localparam int CH_MM_ADDR_W = 14;
    localparam int CH_MM_DATA_W = 64;
    localparam int CH_MM_CNT_W  = 16;

    localparam logic [31:0] CH_MM_ERR_TAG = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        FLUSH   = 2'd2
    } ch_mm_state_e;

endpackage : ch_mm_pkg

// File: rtl/ch_mm_req_bridge.sv
// Host-to-decoder CSR request bridge: turns held host requests into single-cycle
// decoder pulses, allows one outstanding read, times reads out and flushes late acks.
module ch_mm_req_bridge
    import ch_mm_pkg::*;
#(
    parameter int ADDR_W    = CH_MM_ADDR_W,
    parameter int DATA_W    = CH_MM_DATA_W,
    parameter int TIMEOUT   = 255,
    parameter int FLUSH_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iHOST_WR_EN,
    input  logic              iHOST_RD_EN,
    input  logic [ADDR_W-1:0] iHOST_ADDR,
    input  logic [DATA_W-1:0] iHOST_WR_DATA,
    output logic              oHOST_WAIT,
    output logic [DATA_W-1:0] oHOST_RD_DATA,
    output logic              oHOST_RD_DATA_V,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic [15:0]       oTIMEOUT_CNT,
    output logic              oPROTO_ERR
);

    localparam logic [CH_MM_CNT_W-1:0] TO_LAST = CH_MM_CNT_W'(TIMEOUT - 1);
    localparam logic [CH_MM_CNT_W-1:0] FL_LAST = CH_MM_CNT_W'(FLUSH_CYC - 1);

    ch_mm_state_e           state_q, state_d;
    logic [CH_MM_CNT_W-1:0] cnt_q, cnt_d;

    logic              mm_wr_en_d;
    logic              mm_rd_en_d;
    logic [ADDR_W-1:0] mm_addr_d;
    logic [DATA_W-1:0] mm_wr_data_d;
    logic [DATA_W-1:0] host_rd_data_d;
    logic              host_rd_data_v_d;
    logic [15:0]       timeout_cnt_d;
    logic              proto_err_d;
    logic [DATA_W-1:0] err_word;

    // Error return identifies the dead address under a recognisable tag.
    assign err_word   = DATA_W'({CH_MM_ERR_TAG, 32'(oMM_ADDR)});
    assign oHOST_WAIT = (state_q != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        mm_wr_en_d       = 1'b0;
        mm_rd_en_d       = 1'b0;
        mm_addr_d        = oMM_ADDR;
        mm_wr_data_d     = oMM_WR_DATA;
        host_rd_data_d   = oHOST_RD_DATA;
        host_rd_data_v_d = 1'b0;
        timeout_cnt_d    = oTIMEOUT_CNT;
        proto_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iHOST_WR_EN) begin
                    // A write always wins; a read requested alongside it is dropped.
                    mm_wr_en_d   = 1'b1;
                    mm_addr_d    = iHOST_ADDR;
                    mm_wr_data_d = iHOST_WR_DATA;
                    proto_err_d  = iHOST_RD_EN;
                end else if (iHOST_RD_EN) begin
                    mm_rd_en_d = 1'b1;
                    mm_addr_d  = iHOST_ADDR;
                    cnt_d      = '0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (iMM_RD_DATA_V) begin
                    host_rd_data_d   = iMM_RD_DATA;
                    host_rd_data_v_d = 1'b1;
                    state_d          = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    host_rd_data_d   = err_word;
                    host_rd_data_v_d = 1'b1;
                    if (oTIMEOUT_CNT != 16'hFFFF) begin
                        timeout_cnt_d = oTIMEOUT_CNT + 16'd1;
                    end
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                // Acks arriving here belong to the dead read and are dropped.
                if (cnt_q == FL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            oMM_WR_EN       <= 1'b0;
            oMM_RD_EN       <= 1'b0;
            oMM_ADDR        <= '0;
            oMM_WR_DATA     <= '0;
            oHOST_RD_DATA   <= '0;
            oHOST_RD_DATA_V <= 1'b0;
            oTIMEOUT_CNT    <= '0;
            oPROTO_ERR      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            oMM_WR_EN       <= mm_wr_en_d;
            oMM_RD_EN       <= mm_rd_en_d;
            oMM_ADDR        <= mm_addr_d;
            oMM_WR_DATA     <= mm_wr_data_d;
            oHOST_RD_DATA   <= host_rd_data_d;
            oHOST_RD_DATA_V <= host_rd_data_v_d;
            oTIMEOUT_CNT    <= timeout_cnt_d;
            oPROTO_ERR      <= proto_err_d;
        end
    end

endmodule : ch_mm_req_bridge

// File: tb/tb_ch_mm_req_bridge.sv
// Self-checking bench for ch_mm_req_bridge: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-numbered reference model.
module tb_ch_mm_req_bridge;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 64;
    localparam int TIMEOUT   = 8;
    localparam int FLUSH_CYC = 16;

    logic              clk;
    logic              rst_n;
    logic              iHOST_WR_EN;
    logic              iHOST_RD_EN;
    logic [ADDR_W-1:0] iHOST_ADDR;
    logic [DATA_W-1:0] iHOST_WR_DATA;
    logic              oHOST_WAIT;
    logic [DATA_W-1:0] oHOST_RD_DATA;
    logic              oHOST_RD_DATA_V;
    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [DATA_W-1:0] oMM_WR_DATA;
    logic [DATA_W-1:0] iMM_RD_DATA;
    logic              iMM_RD_DATA_V;
    logic [15:0]       oTIMEOUT_CNT;
    logic              oPROTO_ERR;

    ch_mm_req_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iHOST_WR_EN    (iHOST_WR_EN),
        .iHOST_RD_EN    (iHOST_RD_EN),
        .iHOST_ADDR     (iHOST_ADDR),
        .iHOST_WR_DATA  (iHOST_WR_DATA),
        .oHOST_WAIT     (oHOST_WAIT),
        .oHOST_RD_DATA  (oHOST_RD_DATA),
        .oHOST_RD_DATA_V(oHOST_RD_DATA_V),
        .oMM_WR_EN      (oMM_WR_EN),
        .oMM_RD_EN      (oMM_RD_EN),
        .oMM_ADDR       (oMM_ADDR),
        .oMM_WR_DATA    (oMM_WR_DATA),
        .iMM_RD_DATA    (iMM_RD_DATA),
        .iMM_RD_DATA_V  (iMM_RD_DATA_V),
        .oTIMEOUT_CNT   (oTIMEOUT_CNT),
        .oPROTO_ERR     (oPROTO_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: the bridge is described by absolute cycle numbers -- the cycle a
    // read was accepted and the first cycle after a flush window -- rather than a state.
    int              cyc         = 0;
    int              rd_since    = -1;
    int              flush_until = 0;
    logic            e_wait      = 1'b0;
    logic            e_wr        = 1'b0;
    logic            e_rd        = 1'b0;
    logic            e_rdv       = 1'b0;
    logic            e_proto     = 1'b0;
    logic [ADDR_W-1:0] e_addr    = '0;
    logic [DATA_W-1:0] e_wdata   = '0;
    logic [DATA_W-1:0] e_rdata   = '0;
    logic [15:0]     e_tcnt      = '0;

    function automatic bit busy(input int t);
        return (rd_since >= 0) || (t < flush_until);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; rd_since = -1; flush_until = 0;
                e_wait = 0; e_wr = 0; e_rd = 0; e_rdv = 0; e_proto = 0;
                e_addr = '0; e_wdata = '0; e_rdata = '0; e_tcnt = '0;
            end else begin
                int t;
                t = cyc;
                e_wr = 0; e_rd = 0; e_rdv = 0; e_proto = 0;
                if (!busy(t)) begin
                    if (iHOST_WR_EN) begin
                        e_wr = 1; e_addr = iHOST_ADDR; e_wdata = iHOST_WR_DATA; e_proto = iHOST_RD_EN;
                    end else if (iHOST_RD_EN) begin
                        e_rd = 1; e_addr = iHOST_ADDR; rd_since = t;
                    end
                end else if (rd_since >= 0) begin
                    if (iMM_RD_DATA_V) begin
                        e_rdata = iMM_RD_DATA; e_rdv = 1; rd_since = -1;
                    end else if (t - rd_since == TIMEOUT) begin
                        e_rdata = {32'hDEAD_BEEF, 32'(e_addr)};
                        e_rdv = 1;
                        if (e_tcnt != 16'hFFFF) e_tcnt = e_tcnt + 16'd1;
                        rd_since = -1;
                        flush_until = t + 1 + FLUSH_CYC;
                    end
                end
                cyc = t + 1;
                e_wait = busy(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_wait",  oHOST_WAIT,      e_wait);
            check("cmp_wr_en", oMM_WR_EN,       e_wr);
            check("cmp_rd_en", oMM_RD_EN,       e_rd);
            check("cmp_addr",  oMM_ADDR,        e_addr);
            check("cmp_wdata", oMM_WR_DATA,     e_wdata);
            check("cmp_rdv",   oHOST_RD_DATA_V, e_rdv);
            check("cmp_rdata", oHOST_RD_DATA,   e_rdata);
            check("cmp_tcnt",  oTIMEOUT_CNT,    e_tcnt);
            check("cmp_proto", oPROTO_ERR,      e_proto);
            check("cmp_excl",  oMM_WR_EN & oMM_RD_EN, 1'b0);
        end
    end

    task automatic drive_idle();
        iHOST_WR_EN = 1'b0;
        iHOST_RD_EN = 1'b0;
    endtask

    // Presents a request and holds it until the edge that accepts it; returns just after that edge.
    task automatic issue(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        iHOST_WR_EN = wr; iHOST_RD_EN = rd; iHOST_ADDR = a; iHOST_WR_DATA = d;
        for (int i = 0; i < 200; i++) begin
            if (!oHOST_WAIT) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_in_budget", ok, 1'b1);
    endtask

    // Called at a negedge: one-cycle decoder ack, returns at the following negedge.
    task automatic ack_now(input logic [DATA_W-1:0] d);
        iMM_RD_DATA = d;
        iMM_RD_DATA_V = 1'b1;
        @(negedge clk);
        iMM_RD_DATA_V = 1'b0;
    endtask

    // Read accepted in cycle N, ack driven in cycle N+dly; returns in cycle N+dly+1.
    task automatic do_read(input logic [ADDR_W-1:0] a, input int dly, input logic [DATA_W-1:0] d);
        issue(1'b0, 1'b1, a, '0);
        @(negedge clk);
        drive_idle();
        repeat (dly - 1) @(negedge clk);
        ack_now(d);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        iHOST_ADDR = '0; iHOST_WR_DATA = '0; iMM_RD_DATA = '0; iMM_RD_DATA_V = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wait",  oHOST_WAIT,    1'b0);
        check("rst_tcnt",  oTIMEOUT_CNT,  16'h0);
        check("rst_rdata", oHOST_RD_DATA, 64'h0);
        rst_n = 1'b1;

        // Single write, then three back-to-back writes.
        issue(1'b1, 1'b0, 14'h0812, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        check("wr_pulse", oMM_WR_EN,   1'b1);
        check("wr_addr",  oMM_ADDR,    14'h0812);
        check("wr_data",  oMM_WR_DATA, 64'h1234_5678_9ABC_DEF0);
        check("wr_wait",  oHOST_WAIT,  1'b0);
        drive_idle();
        @(negedge clk);
        check("wr_single", oMM_WR_EN, 1'b0);
        issue(1'b1, 1'b0, 14'h0100, 64'h1);
        issue(1'b1, 1'b0, 14'h0101, 64'h2);
        issue(1'b1, 1'b0, 14'h0102, 64'h3);
        @(negedge clk);
        check("b2b_pulse", oMM_WR_EN, 1'b1);
        check("b2b_addr",  oMM_ADDR,  14'h0102);
        drive_idle();

        // Read acked after 5 cycles, with a second read held through the wait.
        issue(1'b0, 1'b1, 14'h1400, '0);
        @(negedge clk);
        check("rd_pulse", oMM_RD_EN,  1'b1);
        check("rd_wait",  oHOST_WAIT, 1'b1);
        iHOST_ADDR = 14'h0222;
        @(negedge clk);
        check("rd_single", oMM_RD_EN, 1'b0);
        repeat (3) @(negedge clk);
        ack_now(64'hCAFE);
        check("rd_ret_v",    oHOST_RD_DATA_V, 1'b1);
        check("rd_ret_data", oHOST_RD_DATA,   64'hCAFE);
        check("rd_ret_wait", oHOST_WAIT,      1'b0);
        @(negedge clk);
        check("rd2_pulse", oMM_RD_EN, 1'b1);
        check("rd2_addr",  oMM_ADDR,  14'h0222);
        drive_idle();
        @(negedge clk);
        ack_now(64'h5555);
        check("rd2_ret", oHOST_RD_DATA, 64'h5555);

        // Timeout, late ack during flush, then a clean read.
        issue(1'b0, 1'b1, 14'h3FFF, '0);
        @(negedge clk);
        drive_idle();
        repeat (7) @(negedge clk);
        check("to_pending", oHOST_RD_DATA_V, 1'b0);
        @(negedge clk);
        check("to_v",    oHOST_RD_DATA_V, 1'b1);
        check("to_data", oHOST_RD_DATA,   64'hDEAD_BEEF_0000_3FFF);
        check("to_cnt",  oTIMEOUT_CNT,    16'd1);
        check("to_wait", oHOST_WAIT,      1'b1);
        repeat (3) @(negedge clk);
        ack_now(64'h0BAD);
        check("late_ack_drop", oHOST_RD_DATA_V, 1'b0);
        check("late_ack_hold", oHOST_RD_DATA,   64'hDEAD_BEEF_0000_3FFF);
        repeat (11) @(negedge clk);
        check("flush_last_wait", oHOST_WAIT, 1'b1);
        @(negedge clk);
        check("flush_done_wait", oHOST_WAIT, 1'b0);
        do_read(14'h0040, 3, 64'h0BAD_F00D);
        check("post_to_rd", oHOST_RD_DATA, 64'h0BAD_F00D);

        // Ack in the very cycle the timeout would expire.
        do_read(14'h0777, TIMEOUT, 64'h7777);
        check("tie_v",    oHOST_RD_DATA_V, 1'b1);
        check("tie_data", oHOST_RD_DATA,   64'h7777);
        check("tie_cnt",  oTIMEOUT_CNT,    16'd1);

        // Write and read together.
        issue(1'b1, 1'b1, 14'h0001, 64'hAB);
        @(negedge clk);
        check("pe_wr",    oMM_WR_EN,  1'b1);
        check("pe_rd",    oMM_RD_EN,  1'b0);
        check("pe_pulse", oPROTO_ERR, 1'b1);
        check("pe_wait",  oHOST_WAIT, 1'b0);
        drive_idle();
        @(negedge clk);
        check("pe_single", oPROTO_ERR, 1'b0);

        // Reset while a read is outstanding.
        issue(1'b0, 1'b1, 14'h0AAA, '0);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wait",  oHOST_WAIT,    1'b0);
        check("mid_rst_addr",  oMM_ADDR,      14'h0);
        check("mid_rst_rdata", oHOST_RD_DATA, 64'h0);
        check("mid_rst_tcnt",  oTIMEOUT_CNT,  16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_now(64'h77);
        check("stray_ack", oHOST_RD_DATA_V, 1'b0);
        do_read(14'h0123, 4, 64'h4242);
        check("post_rst_v",    oHOST_RD_DATA_V, 1'b1);
        check("post_rst_data", oHOST_RD_DATA,   64'h4242);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                issue(1'b1, 1'b0, ADDR_W'($urandom), {$urandom, $urandom});
            end else if (op <= 6) begin
                if ($urandom_range(0, 7) == 0) begin
                    issue(1'b0, 1'b1, ADDR_W'($urandom), '0);
                    @(negedge clk);
                    drive_idle();
                end else begin
                    do_read(ADDR_W'($urandom), $urandom_range(1, TIMEOUT + FLUSH_CYC + 4),
                            {$urandom, $urandom});
                end
            end else if (op == 7) begin
                issue(1'b1, 1'b1, ADDR_W'($urandom), {$urandom, $urandom});
            end else if (op == 8) begin
                @(negedge clk);
                drive_idle();
                ack_now({$urandom, $urandom});
            end else begin
                @(negedge clk);
                drive_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        @(negedge clk);
        drive_idle();
        repeat (TIMEOUT + FLUSH_CYC + 2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ch_mm_req_bridge
